lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit directly downstream of the ALU: the ALU result is the effective address, and RS2 is the store data.
- Accepts one memory op per handshake and drives a req/gnt/rvalid data-memory bus, generating byte enables and lane-replicated store data.
- Extracts and sign- or zero-extends load data and produces a registered writeback beat toward the register file.
- Misaligned and unsupported-width ops are trapped without any bus access.

Parameters:
DATA_WIDTH, 32, datapath/bus data width (only 32 supported)
ADDR_WIDTH, 32, address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-high reset
REQ_VALID  in  1  EX stage presents a memory op
REQ_READY  out  1  unit can accept an op
IS_STORE_IN  in  1  1=store, 0=load
FUNCT3_IN  in  3  RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ALU_OUT_IN  in  ADDR_WIDTH  effective address
RS2_IN  in  DATA_WIDTH  store data
RD_IN  in  5  load destination register
MEM_REQ  out  1  bus request
MEM_WE  out  1  1=write
MEM_ADDR  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
MEM_WDATA  out  DATA_WIDTH  lane-replicated store data
MEM_BE  out  4  byte enables
MEM_GNT  in  1  request accepted
MEM_RVALID  in  1  read data valid
MEM_RDATA  in  DATA_WIDTH  read data
WB_VALID  out  1  one-cycle writeback pulse
WB_RD  out  5  writeback register
WB_DATA  out  DATA_WIDTH  extended load result
EXC_VALID  out  1  one-cycle exception pulse
EXC_CAUSE  out  1  0=misaligned, 1=unsupported funct3
EXC_ADDR  out  ADDR_WIDTH  faulting address
BUSY  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, RST=1):
  - State returns to IDLE.
  - All registered outputs (MEM_*, WB_*, EXC_*) go to 0.
  - REQ_READY is forced to 0 while RST is high.
  - An in-flight transaction is abandoned and produces no WB or EXC. Any late MEM_RVALID after reset is ignored.
- REQ_READY: equals (state==IDLE && !RST). An op is accepted when REQ_VALID && REQ_READY at a rising edge. The address, data, funct3, rd and store flag are latched at that edge.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other encoding gives EXC_CAUSE=1.
- Misalignment check (applies only to legal funct3; the unsupported-width check has priority):
  - Halfword ops misalign when addr[0]=1.
  - Word ops misalign when addr[1:0]!=0.
- On an exception, the cycle after acceptance has EXC_VALID=1 and EXC_ADDR=latched address. There is no bus access and the state stays IDLE, so the next op can be accepted in that same cycle.
- FSM, legal and aligned ops:
  - IDLE -> REQ on accept.
  - REQ: MEM_REQ=1. MEM_ADDR, MEM_WE, MEM_WDATA and MEM_BE are held stable until MEM_GNT is sampled high.
  - REQ with GNT: a store goes to IDLE with no WB; a load goes to WAIT. MEM_REQ is 0 from the next cycle.
  - WAIT: on MEM_RVALID, go to IDLE. In the following cycle WB_VALID=1, WB_RD=rd, WB_DATA=result.
  - If the load has rd=0, WB_VALID stays 0, but the bus access still completes.
- Store formatting, with off = addr[1:0]:
  - SB: WDATA = {4{rs2[7:0]}}, BE = 4'b0001<<off.
  - SH: WDATA = {2{rs2[15:0]}}, BE = 4'b0011<<off.
  - SW: WDATA = rs2, BE = 4'b1111.
- Load MEM_BE uses the same rule as stores; MEM_WDATA=0 on loads.
- Load extraction: sh = MEM_RDATA >> (8*off).
  - B: sign-extend sh[7:0].
  - BU: zero-extend sh[7:0].
  - H: sign-extend sh[15:0].
  - HU: zero-extend sh[15:0].
  - W: MEM_RDATA unchanged.
- Bus timing:
  - MEM_RVALID is guaranteed at least 1 cycle after GNT.
  - MEM_RVALID in IDLE or REQ is ignored.
  - MEM_GNT outside REQ is ignored.
- Latency:
  - Zero-wait load: accept at edge 0, MEM_REQ in cycle 1, GNT in cycle 1, RVALID in cycle 2, WB_VALID in cycle 3.
  - Zero-wait store: accept at edge 0, MEM_REQ/GNT in cycle 1, IDLE again in cycle 2.
- WB_VALID and REQ_READY may be high in the same cycle, so back-to-back ops are allowed.
- EXC_VALID and WB_VALID are never high together.

Test Plan:
1. LW addr=0x100, RDATA=0xDEADBEEF, rd=5, gnt and rvalid zero-wait -> MEM_ADDR=0x100, BE=1111; WB_VALID pulses 3 cycles after accept with WB_RD=5, WB_DATA=0xDEADBEEF.
2. LB addr=0x103 then LBU addr=0x103, RDATA=0x80FF0011 -> WB_DATA=0xFFFFFF80, then 0x00000080; MEM_ADDR=0x100 and BE=1000 for both.
3. SH addr=0x202, rs2=0x1234ABCD, GNT withheld for 3 cycles -> MEM_REQ held 4 cycles with WDATA=0xABCDABCD, BE=1100, WE=1 stable throughout; no WB; REQ_READY returns the cycle after GNT.
4. LW addr=0x101, then SH addr=0x3 -> each gives EXC_VALID=1, EXC_CAUSE=0, EXC_ADDR=0x101 / 0x3; MEM_REQ never asserted.
5. Load funct3=011, and store funct3=100 -> EXC_CAUSE=1, no bus access. LH rd=0 -> bus access occurs, WB_VALID stays 0.
6. Assert RST while in WAIT, then pulse MEM_RVALID after release -> all outputs 0, BUSY=0, no WB_VALID; a fresh LW afterwards completes normally.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Handshake from EX, data-memory bus and writeback/exception outputs of the LSU.
interface lsu_mem_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    // EX-stage request
    logic                    REQ_VALID;
    logic                    REQ_READY;
    logic                    IS_STORE_IN;
    logic [2:0]              FUNCT3_IN;
    logic [ADDR_WIDTH-1:0]   ALU_OUT_IN;
    logic [DATA_WIDTH-1:0]   RS2_IN;
    logic [4:0]              RD_IN;

    // data-memory bus
    logic                    MEM_REQ;
    logic                    MEM_WE;
    logic [ADDR_WIDTH-1:0]   MEM_ADDR;
    logic [DATA_WIDTH-1:0]   MEM_WDATA;
    logic [DATA_WIDTH/8-1:0] MEM_BE;
    logic                    MEM_GNT;
    logic                    MEM_RVALID;
    logic [DATA_WIDTH-1:0]   MEM_RDATA;

    // writeback / exception / status
    logic                    WB_VALID;
    logic [4:0]              WB_RD;
    logic [DATA_WIDTH-1:0]   WB_DATA;
    logic                    EXC_VALID;
    logic                    EXC_CAUSE;
    logic [ADDR_WIDTH-1:0]   EXC_ADDR;
    logic                    BUSY;

    // LSU side
    modport slave (
        input  REQ_VALID, IS_STORE_IN, FUNCT3_IN, ALU_OUT_IN, RS2_IN, RD_IN,
        input  MEM_GNT, MEM_RVALID, MEM_RDATA,
        output REQ_READY,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
        output WB_VALID, WB_RD, WB_DATA,
        output EXC_VALID, EXC_CAUSE, EXC_ADDR, BUSY
    );

    // pipeline / memory side
    modport master (
        output REQ_VALID, IS_STORE_IN, FUNCT3_IN, ALU_OUT_IN, RS2_IN, RD_IN,
        output MEM_GNT, MEM_RVALID, MEM_RDATA,
        input  REQ_READY,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE,
        input  WB_VALID, WB_RD, WB_DATA,
        input  EXC_VALID, EXC_CAUSE, EXC_ADDR, BUSY
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: one op per handshake, req/gnt/rvalid bus,
// byte-lane formatting, load extension and trap on misaligned/unsupported ops.
module lsu_mem_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RST,
    lsu_mem_stage_if.slave bus
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // request decode
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_unsup;
    logic                  w_misal;
    logic                  w_exc;
    logic [1:0]            w_off;
    logic [BE_WIDTH-1:0]   w_be;
    logic [DATA_WIDTH-1:0] w_wdata;

    // latched op context
    logic [1:0]            r_off,   w_off_nxt;
    logic [2:0]            r_f3,    w_f3_nxt;
    logic [4:0]            r_rd,    w_rd_nxt;
    logic                  r_store, w_store_nxt;

    // registered outputs
    logic                  r_mem_req,   w_mem_req_nxt;
    logic                  r_mem_we,    w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_WIDTH-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [BE_WIDTH-1:0]   r_mem_be,    w_mem_be_nxt;
    logic                  r_wb_valid,  w_wb_valid_nxt;
    logic [4:0]            r_wb_rd,     w_wb_rd_nxt;
    logic [DATA_WIDTH-1:0] r_wb_data,   w_wb_data_nxt;
    logic                  r_exc_valid, w_exc_valid_nxt;
    logic                  r_exc_cause, w_exc_cause_nxt;
    logic [ADDR_WIDTH-1:0] r_exc_addr,  w_exc_addr_nxt;

    // load extraction
    logic [7:0]            w_ld_byte;
    logic [15:0]           w_ld_half;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_ready  = (r_state == S_IDLE) && !RST;
    assign w_accept = bus.REQ_VALID && w_ready;
    assign w_off    = bus.ALU_OUT_IN[1:0];

    // Classify the presented op and build its byte enables and lane-replicated store data.
    always_comb begin
        w_unsup = 1'b1;
        w_misal = 1'b0;
        w_be    = 4'b1111;
        w_wdata = bus.RS2_IN;
        case (bus.FUNCT3_IN)
            3'b000, 3'b001, 3'b010: w_unsup = 1'b0;
            3'b100, 3'b101:         w_unsup = bus.IS_STORE_IN;
            default:                w_unsup = 1'b1;
        endcase
        case (bus.FUNCT3_IN[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{bus.RS2_IN[7:0]}};
            end
            2'b01: begin
                w_misal = w_off[0];
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{bus.RS2_IN[15:0]}};
            end
            2'b10: begin
                w_misal = (w_off != 2'b00);
            end
            default: begin
                w_misal = 1'b0;
            end
        endcase
        // unsupported width wins; the cause bit below reports it
        w_exc = w_unsup || w_misal;
    end

    // Pick the addressed lane of the returned word and extend it.
    always_comb begin
        case (r_off)
            2'b00:   w_ld_byte = bus.MEM_RDATA[7:0];
            2'b01:   w_ld_byte = bus.MEM_RDATA[15:8];
            2'b10:   w_ld_byte = bus.MEM_RDATA[23:16];
            default: w_ld_byte = bus.MEM_RDATA[31:24];
        endcase
        w_ld_half = r_off[1] ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0];
        case (r_f3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = bus.MEM_RDATA;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; trapped ops never leave IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && !w_exc) w_state_nxt = S_REQ;
            S_REQ:  if (bus.MEM_GNT)        w_state_nxt = r_store ? S_IDLE : S_WAIT;
            S_WAIT: if (bus.MEM_RVALID)     w_state_nxt = S_IDLE;
            default:                        w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values of the bus, writeback and exception registers.
    always_comb begin
        w_off_nxt       = r_off;
        w_f3_nxt        = r_f3;
        w_rd_nxt        = r_rd;
        w_store_nxt     = r_store;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_be_nxt    = r_mem_be;
        w_wb_valid_nxt  = 1'b0;
        w_wb_rd_nxt     = r_wb_rd;
        w_wb_data_nxt   = r_wb_data;
        w_exc_valid_nxt = 1'b0;
        w_exc_cause_nxt = r_exc_cause;
        w_exc_addr_nxt  = r_exc_addr;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_off_nxt   = w_off;
                    w_f3_nxt    = bus.FUNCT3_IN;
                    w_rd_nxt    = bus.RD_IN;
                    w_store_nxt = bus.IS_STORE_IN;
                    if (w_exc) begin
                        w_exc_valid_nxt = 1'b1;
                        w_exc_cause_nxt = w_unsup;
                        w_exc_addr_nxt  = bus.ALU_OUT_IN;
                    end else begin
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = bus.IS_STORE_IN;
                        w_mem_addr_nxt  = {bus.ALU_OUT_IN[ADDR_WIDTH-1:2], 2'b00};
                        w_mem_wdata_nxt = bus.IS_STORE_IN ? w_wdata : '0;
                        w_mem_be_nxt    = w_be;
                    end
                end
            end
            S_REQ: begin
                if (bus.MEM_GNT) w_mem_req_nxt = 1'b0;
            end
            S_WAIT: begin
                if (bus.MEM_RVALID) begin
                    w_wb_valid_nxt = (r_rd != 5'd0);
                    w_wb_rd_nxt    = r_rd;
                    w_wb_data_nxt  = w_ld_data;
                end
            end
            default: begin
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Output and context registers; reset abandons any in-flight op.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_off       <= '0;
            r_f3        <= '0;
            r_rd        <= '0;
            r_store     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_exc_valid <= 1'b0;
            r_exc_cause <= 1'b0;
            r_exc_addr  <= '0;
        end else begin
            r_off       <= w_off_nxt;
            r_f3        <= w_f3_nxt;
            r_rd        <= w_rd_nxt;
            r_store     <= w_store_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_wb_valid  <= w_wb_valid_nxt;
            r_wb_rd     <= w_wb_rd_nxt;
            r_wb_data   <= w_wb_data_nxt;
            r_exc_valid <= w_exc_valid_nxt;
            r_exc_cause <= w_exc_cause_nxt;
            r_exc_addr  <= w_exc_addr_nxt;
        end
    end

    assign bus.REQ_READY = w_ready;
    assign bus.BUSY      = (r_state != S_IDLE);
    assign bus.MEM_REQ   = r_mem_req;
    assign bus.MEM_WE    = r_mem_we;
    assign bus.MEM_ADDR  = r_mem_addr;
    assign bus.MEM_WDATA = r_mem_wdata;
    assign bus.MEM_BE    = r_mem_be;
    assign bus.WB_VALID  = r_wb_valid;
    assign bus.WB_RD     = r_wb_rd;
    assign bus.WB_DATA   = r_wb_data;
    assign bus.EXC_VALID = r_exc_valid;
    assign bus.EXC_CAUSE = r_exc_cause;
    assign bus.EXC_ADDR  = r_exc_addr;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage against a byte-arithmetic reference model.
module tb_lsu_mem_stage;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;

    lsu_mem_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    lsu_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [2:0] f3);
        return 1 << (f3 % 4);
    endfunction

    function automatic bit op_unsup(input bit st, input logic [2:0] f3);
        if (st) return (f3 > 3'd2);
        return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic logic [3:0] op_be(input logic [2:0] f3, input logic [31:0] addr);
        int nb;
        nb = op_bytes(f3);
        return 4'(((32'd1 << nb) - 32'd1) << (addr % 4));
    endfunction

    function automatic logic [31:0] op_wdata(input logic [2:0] f3, input logic [31:0] d);
        int nb;
        nb = op_bytes(f3);
        if (nb == 1) return 32'(d % 256) * 32'h0101_0101;
        if (nb == 2) return 32'(d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] op_load(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] d);
        longint v;
        longint span;
        int     nb;
        nb = op_bytes(f3);
        if (nb >= 4) return d;
        span = longint'(1) << (8 * nb);
        v    = ({32'd0, d} >> (8 * (addr % 4))) % span;
        if (f3 < 3'd4 && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !bus.REQ_READY; i++) tick();
        check_eq("req_ready_wait", 32'(bus.REQ_READY), 32'd1);
    endtask

    // Drive one op and follow it cycle by cycle; returns in the WB/EXC/idle-again cycle.
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [4:0] rd,
                          input logic [31:0] rdata, input int gd, input int rvd);
        bit          unsup;
        bit          mis;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_wb;
        unsup    = op_unsup(st, f3);
        mis      = !unsup && ((addr % op_bytes(f3)) != 0);
        exp_addr = addr - (addr % 4);
        exp_be   = op_be(f3, addr);
        exp_wd   = st ? op_wdata(f3, rs2) : 32'd0;
        exp_wb   = op_load(f3, addr, rdata);

        wait_ready();
        bus.REQ_VALID   = 1'b1;
        bus.IS_STORE_IN = st;
        bus.FUNCT3_IN   = f3;
        bus.ALU_OUT_IN  = addr;
        bus.RS2_IN      = rs2;
        bus.RD_IN       = rd;
        tick();
        bus.REQ_VALID   = 1'b0;
        bus.IS_STORE_IN = 1'($urandom);
        bus.FUNCT3_IN   = 3'($urandom);
        bus.ALU_OUT_IN  = $urandom;
        bus.RS2_IN      = $urandom;
        bus.RD_IN       = 5'($urandom);

        if (unsup || mis) begin
            check_eq("exc_valid",   32'(bus.EXC_VALID), 32'd1);
            check_eq("exc_cause",   32'(bus.EXC_CAUSE), 32'(unsup));
            check_eq("exc_addr",    bus.EXC_ADDR, addr);
            check_eq("exc_mem_req", 32'(bus.MEM_REQ), 32'd0);
            check_eq("exc_wb",      32'(bus.WB_VALID), 32'd0);
            check_eq("exc_ready",   32'(bus.REQ_READY), 32'd1);
            return;
        end
        check_eq("no_exc", 32'(bus.EXC_VALID), 32'd0);

        for (int g = 0; g <= gd; g++) begin
            bus.MEM_GNT    = (g == gd);
            bus.MEM_RVALID = (g != gd) ? 1'($urandom) : 1'b0;
            bus.MEM_RDATA  = $urandom;
            check_eq("mem_req",   32'(bus.MEM_REQ), 32'd1);
            check_eq("mem_we",    32'(bus.MEM_WE), 32'(st));
            check_eq("mem_addr",  bus.MEM_ADDR, exp_addr);
            check_eq("mem_be",    32'(bus.MEM_BE), 32'(exp_be));
            check_eq("mem_wdata", bus.MEM_WDATA, exp_wd);
            check_eq("req_busy",  32'(bus.BUSY), 32'd1);
            check_eq("req_ready", 32'(bus.REQ_READY), 32'd0);
            check_eq("req_wb",    32'(bus.WB_VALID), 32'd0);
            tick();
        end
        bus.MEM_GNT    = 1'b0;
        bus.MEM_RVALID = 1'b0;
        check_eq("mem_req_drop", 32'(bus.MEM_REQ), 32'd0);

        if (st) begin
            check_eq("st_ready", 32'(bus.REQ_READY), 32'd1);
            check_eq("st_busy",  32'(bus.BUSY), 32'd0);
            check_eq("st_no_wb", 32'(bus.WB_VALID), 32'd0);
            return;
        end

        for (int r = 0; r <= rvd; r++) begin
            bus.MEM_RVALID = (r == rvd);
            bus.MEM_RDATA  = (r == rvd) ? rdata : $urandom;
            bus.MEM_GNT    = 1'($urandom);
            check_eq("wait_busy",  32'(bus.BUSY), 32'd1);
            check_eq("wait_ready", 32'(bus.REQ_READY), 32'd0);
            check_eq("wait_wb",    32'(bus.WB_VALID), 32'd0);
            tick();
        end
        bus.MEM_RVALID = 1'b0;
        bus.MEM_GNT    = 1'b0;
        bus.MEM_RDATA  = $urandom;
        check_eq("wb_valid", 32'(bus.WB_VALID), 32'(rd != 5'd0));
        if (rd != 5'd0) begin
            check_eq("wb_rd",   32'(bus.WB_RD), 32'(rd));
            check_eq("wb_data", bus.WB_DATA, exp_wb);
        end
        check_eq("wb_no_exc", 32'(bus.EXC_VALID), 32'd0);
        check_eq("wb_ready",  32'(bus.REQ_READY), 32'd1);
    endtask

    // Quiet cycles with stray GNT/RVALID that must be ignored.
    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            bus.MEM_GNT    = 1'($urandom);
            bus.MEM_RVALID = 1'($urandom);
            bus.MEM_RDATA  = $urandom;
            tick();
            check_eq("gap_mem_req", 32'(bus.MEM_REQ), 32'd0);
            check_eq("gap_wb",      32'(bus.WB_VALID), 32'd0);
            check_eq("gap_exc",     32'(bus.EXC_VALID), 32'd0);
            check_eq("gap_busy",    32'(bus.BUSY), 32'd0);
        end
        bus.MEM_GNT    = 1'b0;
        bus.MEM_RVALID = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"},   32'(bus.REQ_READY), 32'd0);
        check_eq({tag, "_busy"},    32'(bus.BUSY), 32'd0);
        check_eq({tag, "_mem_req"}, 32'(bus.MEM_REQ), 32'd0);
        check_eq({tag, "_mem_we"},  32'(bus.MEM_WE), 32'd0);
        check_eq({tag, "_addr"},    bus.MEM_ADDR, 32'd0);
        check_eq({tag, "_wdata"},   bus.MEM_WDATA, 32'd0);
        check_eq({tag, "_be"},      32'(bus.MEM_BE), 32'd0);
        check_eq({tag, "_wb"},      32'(bus.WB_VALID), 32'd0);
        check_eq({tag, "_wb_data"}, bus.WB_DATA, 32'd0);
        check_eq({tag, "_exc"},     32'(bus.EXC_VALID), 32'd0);
        check_eq({tag, "_exc_adr"}, bus.EXC_ADDR, 32'd0);
    endtask

    initial begin
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [4:0]  rd;
        int          nb;

        n_checks        = 0;
        n_errors        = 0;
        RST             = 1'b1;
        bus.REQ_VALID   = 1'b0;
        bus.IS_STORE_IN = 1'b0;
        bus.FUNCT3_IN   = 3'd0;
        bus.ALU_OUT_IN  = 32'd0;
        bus.RS2_IN      = 32'd0;
        bus.RD_IN       = 5'd0;
        bus.MEM_GNT     = 1'b0;
        bus.MEM_RVALID  = 1'b0;
        bus.MEM_RDATA   = 32'd0;

        #3;
        check_all_zero("rst");
        tick();
        tick();
        RST = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(bus.REQ_READY), 32'd1);

        // zero-wait word load
        run_op(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0);
        // signed / unsigned byte from top lane
        run_op(1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 32'h80FF_0011, 0, 0);
        run_op(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h80FF_0011, 0, 0);
        // halfword store with delayed grant
        run_op(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd0, 32'h0, 3, 0);
        // misaligned word load, misaligned halfword store
        run_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd1, 32'h0, 0, 0);
        run_op(1'b1, 3'b001, 32'h3, 32'h0, 5'd1, 32'h0, 0, 0);
        // unsupported widths
        run_op(1'b0, 3'b011, 32'h40, 32'h0, 5'd2, 32'h0, 0, 0);
        run_op(1'b1, 3'b100, 32'h41, 32'h0, 5'd2, 32'h0, 0, 0);
        // halfword load to x0 still uses the bus
        run_op(1'b0, 3'b001, 32'h82, 32'h0, 5'd0, 32'hC001_5555, 1, 2);
        // halfword signed/unsigned, byte store
        run_op(1'b0, 3'b001, 32'h86, 32'h0, 5'd9, 32'h8001_7FFF, 0, 1);
        run_op(1'b0, 3'b101, 32'h86, 32'h0, 5'd9, 32'h8001_7FFF, 2, 0);
        run_op(1'b1, 3'b000, 32'h91, 32'hCAFE_BA5E, 5'd0, 32'h0, 0, 0);
        idle_gap(2);

        // reset while waiting for read data
        wait_ready();
        bus.REQ_VALID   = 1'b1;
        bus.IS_STORE_IN = 1'b0;
        bus.FUNCT3_IN   = 3'b010;
        bus.ALU_OUT_IN  = 32'h300;
        bus.RD_IN       = 5'd3;
        tick();
        bus.REQ_VALID = 1'b0;
        bus.MEM_GNT   = 1'b1;
        tick();
        bus.MEM_GNT = 1'b0;
        check_eq("pre_rst_busy", 32'(bus.BUSY), 32'd1);
        RST = 1'b1;
        #1;
        check_all_zero("mid_rst");
        tick();
        RST = 1'b0;
        bus.MEM_RVALID = 1'b1;
        bus.MEM_RDATA  = 32'h1111_2222;
        tick();
        bus.MEM_RVALID = 1'b0;
        check_eq("late_rv_wb", 32'(bus.WB_VALID), 32'd0);
        tick();
        check_eq("late_rv_wb2", 32'(bus.WB_VALID), 32'd0);
        check_eq("late_rv_busy", 32'(bus.BUSY), 32'd0);
        run_op(1'b0, 3'b010, 32'h304, 32'h0, 5'd4, 32'h5A5A_A5A5, 0, 0);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            st   = 1'($urandom);
            f3   = 3'($urandom);
            addr = $urandom;
            nb   = op_bytes(f3);
            if ($urandom_range(3) != 0) addr = addr & ~32'((nb >= 4) ? 3 : nb - 1);
            rd   = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            run_op(st, f3, addr, $urandom, rd, $urandom,
                   int'($urandom_range(3)), int'($urandom_range(3)));
            if ($urandom_range(3) == 0) idle_gap(int'($urandom_range(2)) + 1);
        end
        idle_gap(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
